// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating the read side of a serial NOR flash.
// All SPI pins are oversampled in clk_i. Supports READ (0x03) with a one-byte
// prefetch buffer and JEDEC ID (0x9F). Any other command is ignored until cs rises.
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  sdi,
  output logic                  sdo,
  output logic                  sdo_en,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  active
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StId, StIgnore} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic                   sck_d_q;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, sck_fall, abort;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [2:0]  out_cnt_q;
  logic [6:0]  cmd_sh_q;
  logic [22:0] addr_sh_q;
  logic [6:0]  out_sh_q;
  logic [7:0]  nxt_byte_q;
  logic        cap_q;
  logic [1:0]  id_idx_q;

  logic [7:0]  cmd_next;
  logic [23:0] addr_next;
  logic [7:0]  id_byte;

  // Synchronizers for the SPI pins plus one delayed sck copy for edge detect
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sdi_sync_q <= '0;
      sck_d_q    <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sck_d_q    <= sck_s;
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d_q;
  assign sck_fall  = ~sck_s & sck_d_q;
  // cs high outside IDLE ends the transaction and outranks any sck edge
  assign abort     = (state_q != StIdle) && cs_s;
  assign cmd_next  = {cmd_sh_q, sdi_s};
  assign addr_next = {addr_sh_q, sdi_s};

  // Select the ID byte to send next; 0x00 once the three ID bytes are out
  always_comb begin
    id_byte = 8'h00;
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  // Protocol FSM with registered outputs
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      out_cnt_q  <= '0;
      cmd_sh_q   <= '0;
      addr_sh_q  <= '0;
      out_sh_q   <= '0;
      nxt_byte_q <= '0;
      cap_q      <= 1'b0;
      id_idx_q   <= '0;
      sdo        <= 1'b0;
      sdo_en     <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      active     <= 1'b0;
    end else begin
      active  <= ~cs_s;
      mem_req <= 1'b0;
      // Read data is valid the cycle after mem_req; capture it then
      cap_q   <= mem_req;
      if (cap_q && !abort) nxt_byte_q <= mem_rdata;

      if (abort) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        out_cnt_q <= '0;
        cmd_sh_q  <= '0;
        addr_sh_q <= '0;
        out_sh_q  <= '0;
        id_idx_q  <= '0;
        cap_q     <= 1'b0;
        sdo       <= 1'b0;
        sdo_en    <= 1'b0;
        mem_req   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (!cs_s) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              cmd_sh_q  <= cmd_next[6:0];
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                case (cmd_next)
                  8'h03: state_q <= StAddr;
                  8'h9F: begin
                    state_q   <= StId;
                    sdo_en    <= 1'b1;
                    out_cnt_q <= '0;
                    id_idx_q  <= '0;
                  end
                  default: state_q <= StIgnore;
                endcase
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              addr_sh_q <= addr_next[22:0];
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= '0;
                mem_addr  <= addr_next[ADDR_WIDTH-1:0];
                mem_req   <= 1'b1;
                sdo_en    <= 1'b1;
                out_cnt_q <= '0;
                state_q   <= StData;
              end
            end
          end
          StData: begin
            if (sck_fall) begin
              out_cnt_q <= out_cnt_q + 3'd1;
              if (out_cnt_q == 3'd0) begin
                // Byte boundary: emit buffered byte and prefetch the next one
                sdo      <= nxt_byte_q[7];
                out_sh_q <= nxt_byte_q[6:0];
                mem_addr <= mem_addr + AddrOne;
                mem_req  <= 1'b1;
              end else begin
                sdo      <= out_sh_q[6];
                out_sh_q <= {out_sh_q[5:0], 1'b0};
              end
            end
          end
          StId: begin
            if (sck_fall) begin
              out_cnt_q <= out_cnt_q + 3'd1;
              if (out_cnt_q == 3'd0) begin
                sdo      <= id_byte[7];
                out_sh_q <= id_byte[6:0];
                if (id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
              end else begin
                sdo      <= out_sh_q[6];
                out_sh_q <= {out_sh_q[5:0], 1'b0};
              end
            end
          end
          StIgnore: begin
            sdo    <= 1'b0;
            sdo_en <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
